// File: rtl/iterative_shifter.sv
// Multicycle shift unit: shifts a WIDTH-bit operand by a run-time amount in SLL/SRL/SRA/ROR
// mode, retiring at most STEP positions per clock, with a start/busy/done handshake.
module iterative_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // One bit wider than the counter so STEP == WIDTH is still representable.
  localparam logic [SHW:0] STEP_W  = (SHW + 1)'(STEP);
  localparam logic [SHW:0] WIDTH_W = (SHW + 1)'(WIDTH);

  state_e           r_state;
  mode_e            r_mode;
  logic             r_sign;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_rem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;

  logic [SHW-1:0]   w_k;
  logic [SHW:0]     w_ror_amt;
  logic [WIDTH-1:0] w_fill;
  logic [WIDTH-1:0] w_shifted;
  logic [SHW-1:0]   w_rem_next;

  // Step amount k = min(remaining, STEP); k never exceeds remaining, so no underflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_k        = r_rem;
    w_ror_amt  = '0;
    w_fill     = '0;
    w_shifted  = r_work;
    w_rem_next = '0;

    if ({1'b0, r_rem} >= STEP_W) begin
      w_k = STEP_W[SHW-1:0];
    end
    w_rem_next = r_rem - w_k;
    w_ror_amt  = WIDTH_W - {1'b0, w_k};
    w_fill     = ~({WIDTH{1'b1}} >> w_k);

    case (r_mode)
      MODE_SLL: w_shifted = r_work << w_k;
      MODE_SRL: w_shifted = r_work >> w_k;
      MODE_SRA: w_shifted = (r_work >> w_k) | (r_sign ? w_fill : '0);
      MODE_ROR: w_shifted = (r_work >> w_k) | (r_work << w_ror_amt);
      default:  w_shifted = r_work;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_SLL;
      r_sign  <= 1'b0;
      r_work  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work <= in_data;
            r_mode <= mode_e'(mode);
            r_sign <= in_data[WIDTH-1];
            r_rem  <= shamt;
            if (shamt != '0) begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_out   <= in_data;
            end
          end
        end

        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_out   <= w_shifted;
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out_data = r_out;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: table-driven operations with a result scoreboard, plus
// sequences for ignored mid-operation starts, held start, and reset during an operation.
module tb_iterative_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_data;

  iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .in_data  (in_data),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] expect_v;
  } vec_t;

  int               n_checks;
  int               n_fail;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse consumes one queued expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", {31'd0, done}, 32'd0);
      else                   check("sb_data", out_data, exp_q.pop_front());
    end
  end

  task automatic run_op(input string tag, input logic [1:0] m, input logic [WIDTH-1:0] d,
                        input logic [SHW-1:0] s, input logic [WIDTH-1:0] exp_v);
    int  k;
    int  busy_n;
    int  n;
    bit  seen;
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    in_data = d;
    shamt   = s;
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    start   = 1'b0;
    mode    = 2'($urandom());
    in_data = $urandom();
    shamt   = SHW'($urandom());
    k       = 0;
    busy_n  = 0;
    seen    = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    n = (int'(s) + STEP - 1) / STEP;
    check($sformatf("%s_latency", tag), 32'(k), 32'(n + 1));
    check($sformatf("%s_busy_cycles", tag), 32'(busy_n), 32'(n));
  endtask

  vec_t vecs[$];
  int   done_edges[$];
  int   cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 2'b00;
    in_data  = '0;
    shamt    = '0;

    vecs.push_back('{"sll_1_by_2",      2'b00, 32'h0000_0001,  5'd2, 32'h0000_0004});
    vecs.push_back('{"sra_msb_by_31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF});
    vecs.push_back('{"srl_msb_by_31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001});
    vecs.push_back('{"ror_1_by_1",      2'b11, 32'h0000_0001,  5'd1, 32'h8000_0000});
    vecs.push_back('{"ror_by_8",        2'b11, 32'h1234_5678,  5'd8, 32'h7812_3456});
    vecs.push_back('{"sll_zero",        2'b00, 32'hA5A5_A5A5,  5'd0, 32'hA5A5_A5A5});
    vecs.push_back('{"srl_zero",        2'b01, 32'hA5A5_A5A5,  5'd0, 32'hA5A5_A5A5});
    vecs.push_back('{"sra_zero",        2'b10, 32'hA5A5_A5A5,  5'd0, 32'hA5A5_A5A5});
    vecs.push_back('{"ror_zero",        2'b11, 32'hA5A5_A5A5,  5'd0, 32'hA5A5_A5A5});
    vecs.push_back('{"sll_by_4",        2'b00, 32'hF0F0_F0F0,  5'd4, 32'h0F0F_0F00});
    vecs.push_back('{"sra_pos_by_5",    2'b10, 32'h7000_0000,  5'd5, 32'h0380_0000});
    vecs.push_back('{"sra_neg_by_17",   2'b10, 32'h8000_1234, 5'd17, 32'hFFFF_C000});
    vecs.push_back('{"ror_by_20",       2'b11, 32'h1234_5678, 5'd20, 32'h4567_8123});
    vecs.push_back('{"srl_by_7",        2'b01, 32'hFFFF_FFFF,  5'd7, 32'h01FF_FFFF});

    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_out",  out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].mode, vecs[i].data, vecs[i].shamt, vecs[i].expect_v);

    // Starts pulsed while busy must be ignored; one result, N+1 = 9 clocks after start.
    exp_q.push_back(32'h0000_0001);
    done_edges.delete();
    @(negedge clk);
    start = 1'b1; mode = 2'b01; in_data = 32'h8000_0000; shamt = 5'd31;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (e >= 1 && e <= 4) begin
        start = 1'b1; mode = 2'b00; in_data = 32'h0000_FFFF; shamt = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) done_edges.push_back(e);
    end
    check("midstart_done_count", 32'(done_edges.size()), 32'd1);
    check("midstart_done_edge",  32'(done_edges[0]), 32'd9);

    // Held start: SLL by 9 (N=3) is re-accepted every N+2 = 5 clocks.
    repeat (3) exp_q.push_back(32'h0000_0200);
    done_edges.delete();
    @(negedge clk);
    start = 1'b1; mode = 2'b00; in_data = 32'h0000_0001; shamt = 5'd9;
    for (int e = 0; e < 22; e++) begin
      @(posedge clk);
      if (e == 10) begin
        #1;
        start = 1'b0;
      end
      @(negedge clk);
      if (done) done_edges.push_back(e);
    end
    check("held_done_count", 32'(done_edges.size()), 32'd3);
    check("held_first_done", 32'(done_edges[0]), 32'd4);
    check("held_spacing_1",  32'(done_edges[1] - done_edges[0]), 32'd5);
    check("held_spacing_2",  32'(done_edges[2] - done_edges[1]), 32'd5);

    // Reset in the middle of a shamt=20 operation aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; in_data = 32'hFFFF_FFFF; shamt = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out",  out_data, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    check("abort_out_held", out_data, 32'd0);
    run_op("after_reset_sra", 2'b10, 32'h8000_1234, 5'd17, 32'hFFFF_C000);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iterative_shifter.md
# iterative_shifter

Multicycle shift unit for the datapath's shift instructions and address scaling. Shifts a WIDTH-bit operand by a run-time amount in one of four modes, retiring at most STEP bit positions per clock, with a start/done handshake toward the control unit. Replaces fixed constant shifters wherever the shift amount or direction is not known at design time.

## Interface
- WIDTH, 32, operand and result width; power of two, at least 8.
- STEP, 4, maximum bit positions shifted per clock; power of two, 1 to WIDTH.
- SHW, $clog2(WIDTH), width of the shift amount; derived, not overridden.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled with start.
- in_data  in  WIDTH  operand; sampled with start.
- shamt  in  SHW  shift amount, 0 to WIDTH-1; sampled with start.
- busy  out  1  high while in SHIFT.
- done  out  1  single-cycle completion pulse.
- out_data  out  WIDTH  result; valid from the done cycle, held until the next completion.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 latches in_data, mode, and shamt into the work register and remaining counter. Next state is SHIFT if shamt!=0, otherwise DONE.
- SHIFT: each clock shifts the work register by k = min(remaining, STEP) and sets remaining = remaining - k.
  - When remaining reaches 0 on that edge, the next state is DONE.
- DONE: done=1 for exactly one cycle. out_data is loaded on entry to DONE. The next state is always IDLE.
- Mode rules, applied per step:
  - SLL fills with 0 from the LSB side.
  - SRL fills with 0 from the MSB side.
  - SRA fills with the operand MSB latched at start.
  - ROR moves the bits shifted out of the LSB into the MSB.
- The result equals a single-step shift by the full shamt, modulo WIDTH.
- start is ignored in SHIFT and DONE. It is not queued, and the latched operands are unaffected.
- Input changes after the start cycle have no effect on the operation in progress.
- The remaining counter is SHW bits wide and never underflows, because k is never larger than remaining.

## Timing
- Reset (asynchronous assert):
  - State goes to IDLE.
  - busy=0, done=0, out_data=0, and the work register and counter are cleared.
  - An in-flight operation is aborted with no done pulse, and out_data reads 0.
- Reset release takes effect at the first clk edge with rst_n=1.
- Let N = ceil(shamt/STEP), and let edge 0 be the edge that samples start.
  - busy is high for edges 1..N, i.e. N cycles.
  - done is high in the cycle after edge N+1. Latency is N+1 clocks.
  - For shamt=0, done is high in the cycle after edge 1 and out_data=in_data.
- Back-to-back operation: start may be held high. It is accepted in IDLE, one cycle after DONE, so the minimum issue interval is N+2 clocks.
- Outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
- SLL: WIDTH=32, STEP=4, in_data=0x00000001, shamt=2. Required: out_data=0x00000004, busy high for 1 cycle, done pulse 2 clocks after start.
- SRA: in_data=0x80000000, shamt=31. Required: out_data=0xFFFFFFFF, busy high for 8 cycles, done at 9 clocks. Repeat with SRL; required out_data=0x00000001.
- ROR: in_data=0x00000001, shamt=1. Required: out_data=0x80000000. Then ROR of 0x12345678 by 8. Required: out_data=0x78123456, done at 3 clocks.
- shamt=0 in every mode with in_data=0xA5A5A5A5. Required: out_data=0xA5A5A5A5, done at 1 clock, busy never high.
- Pulse start with different operands while busy, then hold start high continuously. Required: mid-operation starts are ignored and the result is unchanged; held start gives operations spaced N+2 clocks apart.
- Assert rst_n=0 for one cycle in the middle of a shamt=20 operation. Required: busy=0 and out_data=0 immediately, no done pulse, and a new start afterwards completes normally.
